pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter unit. It supersedes the fixed 32-bit, choice-only pc block.
- Generates the fetch address and handshakes it to instruction memory (valid/ready).
- Selects the next PC: sequential, branch (PC-relative), jump (absolute) or trap.
- Defers redirects that arrive while a fetch is blocked, and traps on misaligned targets.
- Sits between the decode/execute redirect logic and the instruction-memory port.

Parameters:
- XLEN, 32: address width in bits.
- RESET_VECTOR, 32'h0000_0000: PC after reset, XLEN bits.
- TRAP_VECTOR, 32'h0000_0100: PC on a trap or a misaligned redirect, XLEN bits.
- ALIGN_BITS, 2: number of low target bits that must be zero. 2 = 4-byte instructions, 1 = compressed allowed.
- INCR, 4: byte increment for the sequential next PC.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- choice  in  2  next-PC select: 00 SEQ, 01 BRANCH, 10 JUMP, 11 TRAP.
- imm  in  XLEN  branch offset, two's complement; used when choice=01.
- target  in  XLEN  absolute jump target; used when choice=10.
- stall  in  1  suppresses sequential advance only.
- fetch_ready  in  1  instruction memory accepts pc_out this cycle.
- fetch_valid  out  1  pc_out is a valid fetch request.
- pc_out  out  XLEN  current fetch address.
- pc_plus  out  XLEN  pc_out + INCR, combinational (link value).
- exc_valid  out  1  one-cycle pulse: misaligned redirect trapped.
- exc_pc  out  XLEN  pc_out at the time of the faulting redirect.
- exc_tval  out  XLEN  the offending misaligned target.

Behaviour:
- Reset, asynchronous: pc_out=RESET_VECTOR, fetch_valid=0, exc_valid=0, exc_pc=0, exc_tval=0, pending cleared, state=BOOT. Reset asserted mid-operation discards any pending redirect immediately.
- States: BOOT, RUN, HOLD.
  - BOOT: fetch_valid=0. Goes to RUN on the first clk edge after reset deasserts; pc_out stays RESET_VECTOR.
  - RUN: fetch_valid=1.
  - HOLD: fetch_valid=1, pc_out frozen, a redirect is pending.
- fire = fetch_valid & fetch_ready.
- Next-PC candidates, all computed from the current pc_out:
  - SEQ = pc_out + INCR.
  - BRANCH = pc_out + imm.
  - JUMP = target with bit0 cleared.
  - TRAP = TRAP_VECTOR.
  - All additions are modulo 2^XLEN; wrap-around is silent.
- Redirect = choice != 00. It is sampled every cycle in RUN, and ignored in BOOT and HOLD.
- Priority: reset > pending redirect > new redirect > stall > sequential.
- RUN, redirect with fire=1: pc_out <= candidate at the next edge (1-cycle latency). State stays RUN.
- RUN, redirect with fire=0: the candidate is captured in the pending register. State goes to HOLD; pc_out is held stable (valid must not drop and the address must not change while unaccepted).
- HOLD: on fire, pc_out <= pending value and state returns to RUN. Further choice values are ignored while in HOLD, so the first redirect wins.
- RUN, choice=00: pc_out <= SEQ only when fire & !stall; otherwise pc_out is held.
- stall with a redirect: the redirect still applies, since stall gates only sequential advance.
- Misalignment check: applies to BRANCH and JUMP candidates; the check on a JUMP candidate is done after bit0 is cleared. If any of candidate[ALIGN_BITS-1:0] is nonzero:
  - The candidate is replaced by TRAP_VECTOR.
  - exc_valid pulses high for exactly one cycle, coincident with the cycle in which pc_out first shows TRAP_VECTOR.
  - exc_pc = pc_out of the redirecting cycle; exc_tval = raw candidate.
  - The check is performed at capture time, so deferred redirects report the same values.
- TRAP choice never raises exc_valid.
- exc_pc and exc_tval hold their values until the next exception or reset.
- pc_plus is purely combinational from pc_out; no reset dependency beyond pc_out.

Decomposition:
- Package pc_pkg holds:
  - pc_sel_e enum {PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10, PC_TRAP=2'b11}.
  - pc_state_e enum {BOOT, RUN, HOLD}.
- One combinational sub-module, pc_next_calc: takes pc_out, choice, imm and target; returns the candidate and a misaligned flag. It is parametrised by XLEN, INCR, ALIGN_BITS and TRAP_VECTOR.
- The top holds the FSM, the pending register and the exception registers.

Test Plan:
- Reset/boot: reset=1 for 2 cycles, then 0, fetch_ready=1, choice=00 → cycle 1 fetch_valid=0, pc_out=0; then pc_out 0,4,8,12 on consecutive cycles.
- Stall and backpressure: at pc=0x10, stall=1 for 3 cycles → pc_out holds 0x10. Then fetch_ready=0 for 2 cycles → pc_out holds 0x10, fetch_valid stays 1.
- Branch/jump: at pc=0x20, choice=01, imm=-8 → next pc_out=0x18. Then choice=10, target=0x81 → pc_out=0x80.
- Deferred redirect: pc=0x40, fetch_ready=0, choice=01, imm=0x100 → pc_out holds 0x40 (HOLD). A second redirect, choice=10 target=0x200, is ignored. fetch_ready=1 → next pc_out=0x140.
- Misaligned: pc=0x50, choice=01, imm=2 (ALIGN_BITS=2) → pc_out=0x100, exc_valid=1 for one cycle, exc_pc=0x50, exc_tval=0x52. choice=11 → pc_out=0x100, exc_valid=0.
- Async reset mid-HOLD: assert reset between edges → pc_out=RESET_VECTOR and fetch_valid=0 immediately; the pending redirect is not applied after reset releases. Wrap check: pc=0xFFFF_FFFC, SEQ → 0x0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-PC select encoding and FSM states.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_TRAP   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } pc_state_e;

  // Any select other than sequential is a redirect of the fetch stream.
  function automatic logic is_redirect(pc_sel_e sel);
    return sel != PC_SEQ;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC candidate generator with target-alignment check.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     INCR        = 4,
  parameter int unsigned     ALIGN_BITS  = 2,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100)
) (
  input  logic [XLEN-1:0] pc,
  input  pc_sel_e         sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] raw_pc,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'(1) << ALIGN_BITS) - 64'(1));

  logic checked;

  // Raw candidate; only PC-relative and absolute targets are alignment-checked.
  always_comb begin
    raw_pc  = pc + XLEN'(INCR);
    checked = 1'b0;
    case (sel)
      PC_SEQ:    raw_pc = pc + XLEN'(INCR);
      PC_BRANCH: begin
        raw_pc  = pc + imm;
        checked = 1'b1;
      end
      PC_JUMP: begin
        raw_pc  = {target[XLEN-1:1], 1'b0};
        checked = 1'b1;
      end
      PC_TRAP:   raw_pc = TRAP_VECTOR;
      default:   raw_pc = pc + XLEN'(INCR);
    endcase
  end

  assign misaligned = checked && ((raw_pc & ALIGN_MASK) != '0);
  assign next_pc    = misaligned ? TRAP_VECTOR : raw_pc;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch request handshake, redirect deferral under
// backpressure and misaligned-target trapping.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     INCR         = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      choice,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] target,
  input  logic            stall,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus,
  output logic            exc_valid,
  output logic [XLEN-1:0] exc_pc,
  output logic [XLEN-1:0] exc_tval
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fv_q, fv_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_mis_q, pend_mis_d;
  logic [XLEN-1:0] pend_tval_q, pend_tval_d;
  logic            exc_valid_q, exc_valid_d;
  logic [XLEN-1:0] exc_pc_q, exc_pc_d;
  logic [XLEN-1:0] exc_tval_q, exc_tval_d;

  pc_sel_e         sel;
  logic            fire;
  logic            redirect;
  logic [XLEN-1:0] cand_pc;
  logic [XLEN-1:0] raw_pc;
  logic            cand_mis;

  assign sel      = pc_sel_e'(choice);
  assign fire     = fv_q & fetch_ready;
  assign redirect = is_redirect(sel);

  pc_next_calc #(
    .XLEN        (XLEN),
    .INCR        (INCR),
    .ALIGN_BITS  (ALIGN_BITS),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_calc (
    .pc         (pc_q),
    .sel        (sel),
    .imm        (imm),
    .target     (target),
    .next_pc    (cand_pc),
    .raw_pc     (raw_pc),
    .misaligned (cand_mis)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next state: an unaccepted redirect parks the unit in HOLD until the fetch fires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect && !fire) state_d = HOLD;
      HOLD:    if (fire) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Datapath next values; alignment is judged at capture so deferred traps report the same info.
  always_comb begin
    pc_d        = pc_q;
    fv_d        = (state_d != BOOT);
    pend_pc_d   = pend_pc_q;
    pend_mis_d  = pend_mis_q;
    pend_tval_d = pend_tval_q;
    exc_valid_d = 1'b0;
    exc_pc_d    = exc_pc_q;
    exc_tval_d  = exc_tval_q;
    case (state_q)
      RUN: begin
        if (redirect) begin
          if (fire) begin
            pc_d = cand_pc;
            if (cand_mis) begin
              exc_valid_d = 1'b1;
              exc_pc_d    = pc_q;
              exc_tval_d  = raw_pc;
            end
          end else begin
            pend_pc_d   = cand_pc;
            pend_mis_d  = cand_mis;
            pend_tval_d = raw_pc;
          end
        end else if (fire && !stall) begin
          pc_d = cand_pc;
        end
      end
      HOLD: begin
        // pc_q is frozen in HOLD, so it still equals the redirecting cycle's PC.
        if (fire) begin
          pc_d = pend_pc_q;
          if (pend_mis_q) begin
            exc_valid_d = 1'b1;
            exc_pc_d    = pc_q;
            exc_tval_d  = pend_tval_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      fv_q        <= 1'b0;
      pend_pc_q   <= '0;
      pend_mis_q  <= 1'b0;
      pend_tval_q <= '0;
      exc_valid_q <= 1'b0;
      exc_pc_q    <= '0;
      exc_tval_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      fv_q        <= fv_d;
      pend_pc_q   <= pend_pc_d;
      pend_mis_q  <= pend_mis_d;
      pend_tval_q <= pend_tval_d;
      exc_valid_q <= exc_valid_d;
      exc_pc_q    <= exc_pc_d;
      exc_tval_q  <= exc_tval_d;
    end
  end

  assign fetch_valid = fv_q;
  assign pc_out      = pc_q;
  assign pc_plus     = pc_q + XLEN'(INCR);
  assign exc_valid   = exc_valid_q;
  assign exc_pc      = exc_pc_q;
  assign exc_tval    = exc_tval_q;

endmodule
